// File: rtl/param_sync_fifo.sv
// Parameterised single-clock FIFO with count, programmable almost-full/empty flags and overflow/underflow pulses.
// Optional first-word-fall-through output stage is enabled by defining FWFT_EN.
module param_sync_fifo #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 3,
   parameter int AF_LEVEL = (2**ADDR_W) - 2,
   parameter int AE_LEVEL = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              underflow
);

   localparam int              DEPTH    = 2**ADDR_W;
   localparam logic [ADDR_W:0] LP_DEPTH = DEPTH[ADDR_W:0];
   localparam logic [ADDR_W:0] LP_AF    = AF_LEVEL[ADDR_W:0];
   localparam logic [ADDR_W:0] LP_AE    = AE_LEVEL[ADDR_W:0];

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [ADDR_W:0]   r_wptr;
   logic [ADDR_W:0]   r_rptr;
   logic [ADDR_W:0]   r_count;
   logic [DATA_W-1:0] r_rd_data;
   logic              r_ovf;
   logic              r_unf;

   logic              w_full;
   logic              w_empty;
   logic              w_wr_acc;
   logic              w_rd_acc;

   assign w_full   = (r_count == LP_DEPTH);
   assign w_wr_acc = wr_en && !w_full;
   assign w_rd_acc = rd_en && !w_empty;

`ifdef FWFT_EN
   // Head word lives in r_rd_data; count still includes it, so memory never holds more than DEPTH.
   logic r_out_valid;
   logic w_mem_ne;
   logic w_load;

   assign w_empty  = !r_out_valid;
   assign w_mem_ne = (r_wptr != r_rptr);
   assign w_load   = w_mem_ne && (!r_out_valid || w_rd_acc);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_rptr      <= '0;
         r_rd_data   <= '0;
      end else if (w_load) begin
         r_out_valid <= 1'b1;
         r_rptr      <= r_rptr + 1'b1;
         r_rd_data   <= r_mem[r_rptr[ADDR_W-1:0]];
      end else if (w_rd_acc) begin
         r_out_valid <= 1'b0;
      end
   end
`else
   assign w_empty = (r_count == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rptr    <= '0;
         r_rd_data <= '0;
      end else if (w_rd_acc) begin
         r_rptr    <= r_rptr + 1'b1;
         r_rd_data <= r_mem[r_rptr[ADDR_W-1:0]];
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (w_wr_acc) begin
         r_mem[r_wptr[ADDR_W-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else begin
         r_ovf <= wr_en && w_full;
         r_unf <= rd_en && w_empty;
         if (w_wr_acc) begin
            r_wptr <= r_wptr + 1'b1;
         end
         case ({w_wr_acc, w_rd_acc})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign rd_data      = r_rd_data;
   assign full         = w_full;
   assign empty        = w_empty;
   assign almost_full  = (r_count >= LP_AF);
   assign almost_empty = (r_count <= LP_AE);
   assign count        = r_count;
   assign overflow     = r_ovf;
   assign underflow    = r_unf;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed self-checking bench for param_sync_fifo at default parameters.
// Exercises standard mode by default, or the fall-through sequence when FWFT_EN is defined.
module tb_param_sync_fifo;

   logic        clk;
   logic        rst_n;
   logic        wr_en;
   logic [31:0] wr_data;
   logic        rd_en;
   logic [31:0] rd_data;
   logic        full;
   logic        empty;
   logic        almost_full;
   logic        almost_empty;
   logic [3:0]  count;
   logic        overflow;
   logic        underflow;

   int n_tests = 0;
   int n_fail  = 0;

   param_sync_fifo dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .rd_en        (rd_en),
      .rd_data      (rd_data),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_count"}, {28'd0, count}, 32'd0);
      chk({tag, "_rd_data"}, rd_data, 32'd0);
      chk({tag, "_empty"}, {31'd0, empty}, 32'd1);
      chk({tag, "_full"}, {31'd0, full}, 32'd0);
      chk({tag, "_ae"}, {31'd0, almost_empty}, 32'd1);
      chk({tag, "_af"}, {31'd0, almost_full}, 32'd0);
      chk({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
      chk({tag, "_unf"}, {31'd0, underflow}, 32'd0);
   endtask

   initial begin
      rst_n   = 1'b0;
      wr_en   = 1'b0;
      wr_data = '0;
      rd_en   = 1'b0;
      #12;
      chk_reset("por");
      #6;
      rst_n = 1'b1;
      #1;

`ifdef FWFT_EN
      wr_en = 1'b1; wr_data = 32'hA5;
      tick();
      wr_en = 1'b0;
      chk("fw_n_empty", {31'd0, empty}, 32'd1);
      chk("fw_n_count", {28'd0, count}, 32'd1);
      tick();
      chk("fw_n1_empty", {31'd0, empty}, 32'd0);
      chk("fw_n1_data", rd_data, 32'hA5);
      wr_en = 1'b1; wr_data = 32'h5A;
      tick();
      wr_en = 1'b0;
      chk("fw_two_count", {28'd0, count}, 32'd2);
      chk("fw_head_hold", rd_data, 32'hA5);
      rd_en = 1'b1;
      tick();
      chk("fw_next_data", rd_data, 32'h5A);
      chk("fw_next_count", {28'd0, count}, 32'd1);
      tick();
      chk("fw_drain_empty", {31'd0, empty}, 32'd1);
      chk("fw_drain_count", {28'd0, count}, 32'd0);
      tick();
      rd_en = 1'b0;
      chk("fw_unf", {31'd0, underflow}, 32'd1);
      chk("fw_unf_count", {28'd0, count}, 32'd0);
`else
      // Fill to full
      for (int i = 0; i < 8; i++) begin
         wr_en = 1'b1; wr_data = 32'h11 * (i + 1);
         tick();
         chk("fill_count", {28'd0, count}, i + 1);
         chk("fill_af", {31'd0, almost_full}, (i + 1 >= 6) ? 32'd1 : 32'd0);
         chk("fill_full", {31'd0, full}, (i + 1 == 8) ? 32'd1 : 32'd0);
         chk("fill_ae", {31'd0, almost_empty}, (i + 1 <= 2) ? 32'd1 : 32'd0);
         chk("fill_empty", {31'd0, empty}, 32'd0);
      end
      wr_data = 32'h99;
      tick();
      wr_en = 1'b0;
      chk("ovf_pulse", {31'd0, overflow}, 32'd1);
      chk("ovf_count", {28'd0, count}, 32'd8);
      tick();
      chk("ovf_clear", {31'd0, overflow}, 32'd0);

      for (int i = 0; i < 8; i++) begin
         rd_en = 1'b1;
         tick();
         chk("drain_data", rd_data, 32'h11 * (i + 1));
         chk("drain_count", {28'd0, count}, 7 - i);
      end
      chk("drain_empty", {31'd0, empty}, 32'd1);

      tick();
      rd_en = 1'b0;
      chk("unf_pulse", {31'd0, underflow}, 32'd1);
      chk("unf_count", {28'd0, count}, 32'd0);
      chk("unf_hold", rd_data, 32'h88);
      tick();
      chk("unf_clear", {31'd0, underflow}, 32'd0);

      // Steady-state streaming at count=4
      for (int i = 0; i < 4; i++) begin
         wr_en = 1'b1; wr_data = 32'hA0 + i;
         tick();
      end
      chk("stream_pre", {28'd0, count}, 32'd4);
      for (int i = 0; i < 20; i++) begin
         wr_en = 1'b1; rd_en = 1'b1; wr_data = 32'hA4 + i;
         tick();
         chk("stream_data", rd_data, 32'hA0 + i);
         chk("stream_count", {28'd0, count}, 32'd4);
      end
      wr_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rd_en = 1'b1;
         tick();
         chk("stream_tail", rd_data, 32'hB4 + i);
      end
      rd_en = 1'b0;
      chk("stream_empty", {31'd0, empty}, 32'd1);
`endif

      // Asynchronous reset mid-operation at count=5
      for (int i = 0; i < 5; i++) begin
         wr_en = 1'b1; wr_data = 32'hC0 + i;
         tick();
      end
      wr_en = 1'b0;
      chk("pre_rst_count", {28'd0, count}, 32'd5);
      #3;
      rst_n = 1'b0;
      #1;
      chk_reset("async_rst");
      #2;
      rst_n = 1'b1;
      wr_en = 1'b1; wr_data = 32'hD7;
      tick();
      wr_en = 1'b0;
      chk("post_rst_count", {28'd0, count}, 32'd1);
`ifdef FWFT_EN
      tick();
      chk("post_rst_data", rd_data, 32'hD7);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
`else
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk("post_rst_data", rd_data, 32'hD7);
`endif
      chk("post_rst_empty", {31'd0, empty}, 32'd1);
      chk("post_rst_cnt0", {28'd0, count}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
